i2c_codec_config: RTL



---
 rtl/i2c_codec_config_pkg.sv | 22 ++
 rtl/i2c_codec_config_if.sv | 9 +
 rtl/i2c_codec_config_clkdiv.sv | 26 ++
 rtl/i2c_codec_config.sv | 127 ++++++++++++
 4 files changed

// File: rtl/i2c_codec_config_pkg.sv
// codec_cfg_pkg: FSM states, codec constants and the power-up register table
package codec_cfg_pkg;
    typedef enum logic [2:0] {WAIT_PWR, ISSUE, WAIT_BUSY, WAIT_END, CHECK, DONE} state_e;
    localparam int LUT_SIZE = 10;
    localparam logic [7:0] CODEC_ADDR = 8'h34;
    // Activation register (index 9) must stay last so the codec only starts once fully set up
    function automatic logic [15:0] codec_lut(input logic [3:0] idx);
        case (idx)
            4'd0: codec_lut = 16'h001A;
            4'd1: codec_lut = 16'h021A;
            4'd2: codec_lut = 16'h047B;
            4'd3: codec_lut = 16'h067B;
            4'd4: codec_lut = 16'h08F8;
            4'd5: codec_lut = 16'h0A06;
            4'd6: codec_lut = 16'h0C00;
            4'd7: codec_lut = 16'h0E01;
            4'd8: codec_lut = 16'h1002;
            4'd9: codec_lut = 16'h1201;
            default: codec_lut = 16'h0000;
        endcase
    endfunction
endpackage

// File: rtl/i2c_codec_config_if.sv
// i2c_codec_config_if: GO/END/ACK handshake and data word towards the I2C byte serialiser
interface i2c_codec_config_if;
    logic [23:0] I2C_DATA;
    logic GO;
    logic END;
    logic ACK;
    modport master (output I2C_DATA, GO, input END, ACK);
    modport slave (input I2C_DATA, GO, output END, ACK);
endinterface

// File: rtl/i2c_codec_config_clkdiv.sv
// codec_cfg_clkdiv: divides clk by 2*DIV for the serialiser clock; tick_o marks its rising edge
module codec_cfg_clkdiv #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_o,
    output logic tick_o
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q;
    logic clk_q;
    logic wrap;
    assign wrap = cnt_q == W'(DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            clk_q <= wrap ? ~clk_q : clk_q;
        end
    end
    assign clk_o = clk_q;
    assign tick_o = wrap & ~clk_q;
endmodule

// File: rtl/i2c_codec_config.sv
// i2c_codec_config: power-up sequencer writing the codec register table over the I2C serialiser.
// Define CODEC_CFG_RETRY_LIMIT_EN to abandon an entry after MAX_RETRY NACK retries.
module i2c_codec_config
    import codec_cfg_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int I2C_FREQ    = 20_000,
    parameter int START_DELAY = 65_535,
    parameter int MAX_RETRY   = 3
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      RECONFIG,
    output logic                      I2C_CTRL_CLK,
    i2c_codec_config_if.master        bus,
    output logic [3:0]                LUT_INDEX,
    output logic                      CFG_DONE,
    output logic                      CFG_ERR
);
    localparam int DIV = CLK_FREQ / (2 * I2C_FREQ);
    state_e state_q, state_d;
    logic [23:0] data_q, data_d;
    logic [31:0] dly_q, dly_d;
    logic [3:0] idx_q, idx_d, idx_nxt;
    logic go_q, go_d, done_q, done_d, ack_q, ack_d, recfg_q, recfg, tick, adv, give_up;
    codec_cfg_clkdiv #(.DIV(DIV)) u_div (.clk(CLOCK), .rst_n(RESET), .clk_o(I2C_CTRL_CLK), .tick_o(tick));
    // A RECONFIG pulse between ticks is held until the next tick consumes it
    assign recfg = recfg_q | RECONFIG;
    assign adv = ~ack_q | give_up;
    assign idx_nxt = idx_q + 4'(adv);
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= WAIT_PWR;
            data_q  <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            recfg_q <= 1'b0;
        end else begin
            recfg_q <= tick ? 1'b0 : recfg;
            if (tick) begin
                state_q <= state_d;
                data_q  <= data_d;
                dly_q   <= dly_d;
                idx_q   <= idx_d;
                go_q    <= go_d;
                done_q  <= done_d;
                ack_q   <= ack_d;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        if (recfg) state_d = ISSUE;
        else case (state_q)
            WAIT_PWR:  state_d = dly_q == 32'(START_DELAY - 1) ? ISSUE : WAIT_PWR;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = bus.END ? WAIT_BUSY : WAIT_END;
            WAIT_END:  state_d = bus.END ? CHECK : WAIT_END;
            CHECK:     state_d = idx_nxt == 4'(LUT_SIZE) ? DONE : ISSUE;
            default:   state_d = state_q;
        endcase
    end
    always_comb begin
        data_d = data_q;
        dly_d  = dly_q;
        idx_d  = idx_q;
        go_d   = go_q;
        done_d = done_q;
        ack_d  = ack_q;
        if (recfg) begin
            go_d   = 1'b0;
            idx_d  = '0;
            done_d = 1'b0;
        end else case (state_q)
            WAIT_PWR: dly_d = dly_q + 1'b1;
            ISSUE: begin
                data_d = {CODEC_ADDR, codec_lut(idx_q)};
                go_d   = 1'b1;
            end
            WAIT_END: begin
                ack_d = bus.END ? bus.ACK : ack_q;
                go_d  = bus.END ? 1'b0 : go_q;
            end
            CHECK: begin
                idx_d  = idx_nxt;
                done_d = idx_nxt == 4'(LUT_SIZE);
            end
            default: go_d = state_q == DONE ? 1'b0 : go_q;
        endcase
    end
`ifdef CODEC_CFG_RETRY_LIMIT_EN
    logic [7:0] retry_q, retry_d;
    logic err_q, err_d;
    assign give_up = ack_q & (retry_q == 8'(MAX_RETRY));
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            retry_q <= '0;
            err_q   <= 1'b0;
        end else if (tick) begin
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        retry_d = retry_q;
        err_d   = err_q;
        if (recfg) begin
            retry_d = '0;
            err_d   = 1'b0;
        end else if (state_q == CHECK) begin
            retry_d = adv ? '0 : retry_q + 1'b1;
            err_d   = err_q | give_up;
        end
    end
    assign CFG_ERR = err_q;
`else
    assign give_up = 1'b0;
    assign CFG_ERR = 1'b0;
`endif
    assign bus.I2C_DATA = data_q;
    assign bus.GO = go_q;
    assign LUT_INDEX = idx_q;
    assign CFG_DONE = done_q;
endmodule
